// File: rtl/alu_pkg.sv
// Opcodes, FSM states and decode helpers shared by the multicycle ALU.
// Build option: define ALU_MUL_EN to make OP_MUL a legal, iterative opcode.
package alu_pkg;

  localparam int unsigned OPW = 6;

  localparam logic [OPW-1:0] OP_SLL = 6'b000100;
  localparam logic [OPW-1:0] OP_SRL = 6'b000110;
  localparam logic [OPW-1:0] OP_SRA = 6'b000111;
  localparam logic [OPW-1:0] OP_ADD = 6'b100000;
  localparam logic [OPW-1:0] OP_SUB = 6'b100010;
  localparam logic [OPW-1:0] OP_AND = 6'b100100;
  localparam logic [OPW-1:0] OP_OR  = 6'b100101;
  localparam logic [OPW-1:0] OP_XOR = 6'b100110;
  localparam logic [OPW-1:0] OP_SEQ = 6'b101000;
  localparam logic [OPW-1:0] OP_SNE = 6'b101001;
  localparam logic [OPW-1:0] OP_SLT = 6'b101010;
  localparam logic [OPW-1:0] OP_SGT = 6'b101011;
  localparam logic [OPW-1:0] OP_SLE = 6'b101100;
  localparam logic [OPW-1:0] OP_SGE = 6'b101101;
  localparam logic [OPW-1:0] OP_MUL = 6'b011000;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_e;
  typedef enum logic [1:0] {IT_SLL, IT_SRL, IT_SRA, IT_MUL} iter_kind_e;

  function automatic logic is_shift(input logic [OPW-1:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

  function automatic logic is_legal(input logic [OPW-1:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_SLL, OP_SRL, OP_SRA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_SEQ, OP_SNE, OP_SLT, OP_SGT, OP_SLE, OP_SGE: ok = 1'b1;
`ifdef ALU_MUL_EN
      OP_MUL: ok = 1'b1;
`endif
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Illegal opcodes also finish in one cycle, so only legal iterative ops return 0.
  function automatic logic is_single_cycle(input logic [OPW-1:0] op);
    return !(is_shift(op) || ((op == OP_MUL) && is_legal(op)));
  endfunction

endpackage

// File: rtl/alu_mc_iter.sv
// Iterative datapath: variable-step shifter with down-counter, plus shift-add
// multiplier accumulator when ALU_MUL_EN is defined.
module alu_mc_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step,
  input  iter_kind_e       kind,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last_c,
  output logic [WIDTH-1:0] result_c
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned CW  = SHW + 1;
  localparam logic [CW-1:0] STEP = CW'(SHIFT_STEP);

  iter_kind_e       kind_q;
  logic [WIDTH-1:0] sh_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    amt_c;
  logic [WIDTH-1:0] shift_c;

  // Shift by min(STEP, remaining); the last step is the one that empties the counter.
  always_comb begin
    amt_c = (cnt_q < STEP) ? cnt_q : STEP;
    case (kind_q)
      IT_SRL:  shift_c = sh_q >> amt_c;
      IT_SRA:  shift_c = WIDTH'($signed(sh_q) >>> amt_c);
      default: shift_c = sh_q << amt_c;
    endcase
    last_c = (kind_q == IT_MUL) ? (cnt_q == CW'(1)) : (cnt_q <= STEP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kind_q <= IT_SLL;
      sh_q   <= '0;
      cnt_q  <= '0;
    end else if (start) begin
      kind_q <= kind;
      sh_q   <= a;
      cnt_q  <= (kind == IT_MUL) ? CW'(WIDTH) : CW'(b[SHW-1:0]);
    end else if (step) begin
      if (kind_q == IT_MUL) begin
        sh_q  <= sh_q << 1;
        cnt_q <= cnt_q - CW'(1);
      end else begin
        sh_q  <= shift_c;
        cnt_q <= cnt_q - amt_c;
      end
    end
  end

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mpl_q;

  // Multiplicand rides in sh_q; one multiplier bit is consumed per step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      mpl_q <= '0;
    end else if (start) begin
      acc_q <= '0;
      mpl_q <= b;
    end else if (step && (kind_q == IT_MUL)) begin
      if (mpl_q[0]) acc_q <= acc_q + sh_q;
      mpl_q <= mpl_q >> 1;
    end
  end

  assign result_c = (kind_q == IT_MUL) ? (acc_q + (mpl_q[0] ? sh_q : '0)) : shift_c;
`else
  logic unused_b;
  assign unused_b = ^b[WIDTH-1:SHW];
  assign result_c = shift_c;
`endif

endmodule

// File: rtl/alu_mc.sv
// Multicycle ALU with valid/ready handshakes on both sides; single-cycle ops
// resolve at accept, shifts (and MUL under ALU_MUL_EN) iterate in alu_mc_iter.
module alu_mc
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [5:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             illegal
);

  localparam int unsigned SHW = $clog2(WIDTH);

  state_e           state;
  logic             accept;
  logic             start;
  logic             step;
  logic             go_done_c;
  logic [WIDTH-1:0] fast_res_c;
  logic             fast_ovf_c;
  logic             fast_ill_c;
  iter_kind_e       kind_c;
  logic [WIDTH-1:0] sum_c;
  logic [WIDTH-1:0] diff_c;
  logic             eq_c;
  logic             lt_c;
  logic             iter_last_c;
  logic [WIDTH-1:0] iter_res_c;

  assign in_ready = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign accept   = in_valid && in_ready;
  assign step     = (state == ST_BUSY);
  assign start    = accept && !go_done_c;

  // Single-cycle results and the decision whether the accepted op needs iteration.
  always_comb begin
    fast_res_c = '0;
    fast_ovf_c = 1'b0;
    fast_ill_c = 1'b0;
    kind_c     = IT_SLL;
    sum_c      = a + b;
    diff_c     = a - b;
    eq_c       = (a == b);
    lt_c       = ($signed(a) < $signed(b));
    go_done_c  = !is_legal(opcode) || is_single_cycle(opcode) ||
                 (is_shift(opcode) && (b[SHW-1:0] == '0));
    case (opcode)
      OP_ADD: begin
        fast_res_c = sum_c;
        fast_ovf_c = (a[WIDTH-1] == b[WIDTH-1]) && (sum_c[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        fast_res_c = diff_c;
        fast_ovf_c = (a[WIDTH-1] != b[WIDTH-1]) && (diff_c[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: fast_res_c = a & b;
      OP_OR:  fast_res_c = a | b;
      OP_XOR: fast_res_c = a ^ b;
      OP_SEQ: fast_res_c = WIDTH'(eq_c);
      OP_SNE: fast_res_c = WIDTH'(!eq_c);
      OP_SLT: fast_res_c = WIDTH'(lt_c);
      OP_SGT: fast_res_c = WIDTH'(!lt_c && !eq_c);
      OP_SLE: fast_res_c = WIDTH'(lt_c || eq_c);
      OP_SGE: fast_res_c = WIDTH'(!lt_c);
      OP_SLL: begin kind_c = IT_SLL; fast_res_c = a; end
      OP_SRL: begin kind_c = IT_SRL; fast_res_c = a; end
      OP_SRA: begin kind_c = IT_SRA; fast_res_c = a; end
`ifdef ALU_MUL_EN
      OP_MUL: kind_c = IT_MUL;
`endif
      default: fast_ill_c = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      ovf       <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      case (state)
        ST_BUSY: if (iter_last_c) begin
          state     <= ST_DONE;
          out_valid <= 1'b1;
          result    <= iter_res_c;
          ovf       <= 1'b0;
          illegal   <= 1'b0;
        end
        ST_DONE: if (out_ready && !in_valid) begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
        default: ;
      endcase
      // A new accept overrides the DONE->IDLE step so results can stream back-to-back.
      if (accept) begin
        if (go_done_c) begin
          state     <= ST_DONE;
          out_valid <= 1'b1;
          result    <= fast_res_c;
          ovf       <= fast_ovf_c;
          illegal   <= fast_ill_c;
        end else begin
          state     <= ST_BUSY;
          out_valid <= 1'b0;
        end
      end
    end
  end

  alu_mc_iter #(
    .WIDTH      (WIDTH),
    .SHIFT_STEP (SHIFT_STEP)
  ) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .step     (step),
    .kind     (kind_c),
    .a        (a),
    .b        (b),
    .last_c   (iter_last_c),
    .result_c (iter_res_c)
  );

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc: a SHIFT_STEP=1 instance plus a
// SHIFT_STEP=8 instance used only by the shift-step checks.
module tb_alu_mc;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_valid8;
  logic        in_ready, in_ready8;
  logic [31:0] a, b;
  logic [5:0]  opcode;
  logic        out_valid, out_valid8;
  logic        out_ready;
  logic [31:0] result, result8;
  logic        ovf, ovf8;
  logic        illegal, illegal8;

  int tests = 0;
  int fails = 0;

  alu_mc #(.WIDTH(32), .SHIFT_STEP(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .ovf(ovf), .illegal(illegal)
  );

  alu_mc #(.WIDTH(32), .SHIFT_STEP(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a), .b(b), .opcode(opcode), .out_valid(out_valid8), .out_ready(out_ready),
    .result(result8), .ovf(ovf8), .illegal(illegal8)
  );

  always #5 clk = ~clk;

  // Issue one op from IDLE, scramble operands after accept, and report edges until out_valid.
  task automatic run_op(input bit sel, input logic [5:0] op, input logic [31:0] ia,
                        input logic [31:0] ib, output int lat, output logic [31:0] res,
                        output logic ov, output logic il);
    @(negedge clk);
    opcode = op; a = ia; b = ib; out_ready = 1'b0;
    if (sel) in_valid8 = 1'b1; else in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_valid8 = 1'b0;
    a = 32'hDEADBEEF; b = 32'h0000001F; opcode = OP_ADD;
    lat = 1;
    while (!(sel ? out_valid8 : out_valid) && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    res = sel ? result8 : result;
    ov  = sel ? ovf8 : ovf;
    il  = sel ? illegal8 : illegal;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    int lat; logic [31:0] res; logic ov, il;
    rst_n = 1'b0;
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'h0 || ovf !== 1'b0 || illegal !== 1'b0) begin
      fails++;
      $display("FAIL reset_values: out_valid=%b in_ready=%b result=%h ovf=%b illegal=%b, required 0 1 0 0 0",
               out_valid, in_ready, result, ovf, illegal);
    end
    rst_n = 1'b1;
    run_op(1'b0, OP_ADD, 32'd2, 32'd3, lat, res, ov, il);
    tests++;
    if (res !== 32'd5) begin fails++; $display("FAIL pre_reset_add: result=%h required=%h", res, 32'd5); end
    // Start a long SLL, then pull reset while it is iterating.
    @(negedge clk);
    opcode = OP_SLL; a = 32'd1; b = 32'd20; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      fails++; $display("FAIL busy_mid_sll: in_ready=%b out_valid=%b required 0 0", in_ready, out_valid);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'h0) begin
      fails++;
      $display("FAIL reset_mid_sll: out_valid=%b in_ready=%b result=%h required 0 1 00000000", out_valid, in_ready, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL discarded_sll: out_valid=%b required 0", out_valid); end
  endtask

  task automatic test_arith();
    logic [5:0]  ops   [5] = '{OP_ADD, OP_SUB, OP_ADD, OP_SUB, OP_XOR};
    logic [31:0] va    [5] = '{32'h7FFFFFFF, 32'h80000000, 32'd5, 32'd3, 32'hF0F0F0F0};
    logic [31:0] vb    [5] = '{32'd1, 32'd1, 32'd3, 32'd5, 32'hFF00FF00};
    logic [31:0] e_res [5] = '{32'h80000000, 32'h7FFFFFFF, 32'd8, 32'hFFFFFFFE, 32'h0FF00FF0};
    logic        e_ovf [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    int lat; logic [31:0] res; logic ov, il;
    for (int i = 0; i < 5; i++) begin
      run_op(1'b0, ops[i], va[i], vb[i], lat, res, ov, il);
      tests++;
      if (res !== e_res[i] || ov !== e_ovf[i] || lat !== 1) begin
        fails++;
        $display("FAIL arith_%0d: result=%h ovf=%b lat=%0d required result=%h ovf=%b lat=1",
                 i, res, ov, lat, e_res[i], e_ovf[i]);
      end
    end
  endtask

  task automatic test_shift();
    bit          sel   [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [5:0]  ops   [8] = '{OP_SRA, OP_SRA, OP_SLL, OP_SRL, OP_SLL, OP_SRA, OP_SRL, OP_SLL};
    logic [31:0] va    [8] = '{32'h80000000, 32'h80000000, 32'd3, 32'h80000000, 32'hABCD1234,
                               32'h40000000, 32'hF0000000, 32'd1};
    logic [31:0] vb    [8] = '{32'd31, 32'd31, 32'h00000102, 32'd4, 32'h00000020, 32'd4, 32'd9, 32'd8};
    logic [31:0] e_res [8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd12, 32'h08000000, 32'hABCD1234,
                               32'h04000000, 32'h00780000, 32'h00000100};
    int          e_lat [8] = '{32, 5, 3, 5, 1, 5, 3, 2};
    int lat; logic [31:0] res; logic ov, il;
    for (int i = 0; i < 8; i++) begin
      run_op(sel[i], ops[i], va[i], vb[i], lat, res, ov, il);
      tests++;
      if (res !== e_res[i] || lat !== e_lat[i] || ov !== 1'b0) begin
        fails++;
        $display("FAIL shift_%0d: result=%h lat=%0d ovf=%b required result=%h lat=%0d ovf=0",
                 i, res, lat, ov, e_res[i], e_lat[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  ops   [6] = '{OP_SLT, OP_SGT, OP_SLE, OP_SGE, OP_SEQ, OP_SNE};
    logic [31:0] e_res [6] = '{32'd1, 32'd0, 32'd1, 32'd0, 32'd0, 32'd1};
    @(negedge clk);
    out_ready = 1'b1; a = 32'hFFFFFFFF; b = 32'd1; opcode = ops[0]; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b1 || result !== e_res[i] || in_ready !== 1'b1) begin
        fails++;
        $display("FAIL compare_%0d: out_valid=%b result=%h in_ready=%b required 1 %h 1",
                 i, out_valid, result, in_ready, e_res[i]);
      end
      if (i < 5) opcode = ops[i + 1];
      else in_valid = 1'b0;
    end
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL compare_drain: out_valid=%b required 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    out_ready = 1'b0; opcode = OP_AND; a = 32'd5; b = 32'd1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    opcode = OP_OR; a = 32'd4; b = 32'd2;
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (out_valid !== 1'b1 || result !== 32'd1 || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL hold_%0d: out_valid=%b result=%h in_ready=%b required 1 00000001 0", i, out_valid, result, in_ready);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL release_ready: in_ready=%b required 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || result !== 32'd6) begin
      fails++; $display("FAIL next_after_release: out_valid=%b result=%h required 1 00000006", out_valid, result);
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_illegal();
    int lat; logic [31:0] res; logic ov, il;
    run_op(1'b0, 6'b111111, 32'd5, 32'd5, lat, res, ov, il);
    tests++;
    if (il !== 1'b1 || res !== 32'd0 || ov !== 1'b0 || lat !== 1) begin
      fails++; $display("FAIL illegal_op: illegal=%b result=%h ovf=%b lat=%0d required 1 0 0 1", il, res, ov, lat);
    end
    run_op(1'b0, OP_OR, 32'd8, 32'd1, lat, res, ov, il);
    tests++;
    if (il !== 1'b0 || res !== 32'd9) begin
      fails++; $display("FAIL illegal_clears: illegal=%b result=%h required 0 00000009", il, res);
    end
  endtask

  task automatic test_mul();
    int lat; logic [31:0] res; logic ov, il;
    run_op(1'b0, OP_MUL, 32'd7, 32'd6, lat, res, ov, il);
    tests++;
`ifdef ALU_MUL_EN
    if (res !== 32'd42 || lat !== 33 || il !== 1'b0 || ov !== 1'b0) begin
      fails++; $display("FAIL mul: result=%h lat=%0d illegal=%b ovf=%b required 0000002a 33 0 0", res, lat, il, ov);
    end
`else
    if (res !== 32'd0 || lat !== 1 || il !== 1'b1 || ov !== 1'b0) begin
      fails++; $display("FAIL mul_disabled: result=%h lat=%0d illegal=%b ovf=%b required 0 1 1 0", res, lat, il, ov);
    end
`endif
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0;
    in_valid = 1'b0; in_valid8 = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; opcode = '0;
    test_reset();
    test_arith();
    test_shift();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_mul();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
